// File: rtl/aes_cap_pkg.sv
// Shared types and constants for the AES result capture block.
package aes_cap_pkg;

  localparam int AES_W     = 128;
  localparam int AES_BYTES = 16;
  localparam int IDX_W     = $clog2(AES_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_STREAM  = 2'd3
  } cap_state_t;

  // Byte idx of a block, byte 0 being the most significant byte.
  function automatic logic [7:0] aes_byte(input logic [AES_W-1:0] blk,
                                          input logic [IDX_W-1:0] idx);
    logic [AES_W-1:0] sh;
    sh = blk >> {~idx, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/aes_byte_serializer.sv
// Presents a 128-bit block as 16 bytes, MSB first, on a valid/ready port.
// The byte index only moves on an accepted transfer, so a stalled consumer
// sees byte_out and byte_valid held.
module aes_byte_serializer
  import aes_cap_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic [AES_W-1:0] data,
  input  logic             byte_ready,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             last_xfer
);

  logic [IDX_W-1:0] idx_q;
  logic             xfer;

  assign byte_valid = active;
  assign xfer       = active & byte_ready;
  assign last_xfer  = xfer & (idx_q == IDX_W'(AES_BYTES - 1));
  assign byte_out   = active ? aes_byte(data, idx_q) : 8'h00;

  // Byte index: advance per transfer, back to 0 after the last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (xfer) begin
      idx_q <= last_xfer ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/aes_result_capture.sv
// Captures the AES core ciphertext a fixed latency after start, writes it to
// the result RAM, compares it against the golden value and streams it out
// bytewise.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_WAIT    | latency counter running down to the ciphertext-valid edge
// ST_CAPTURE | one cycle: RAM write of the captured ciphertext
// ST_STREAM  | serializing the 16 captured bytes, done on the last one
module aes_result_capture
  import aes_cap_pkg::*;
#(
  parameter int LATENCY = 21,
  parameter int ADDR_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AES_W-1:0]  ct_in,
  input  logic [AES_W-1:0]  expected,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [AES_W-1:0]  ram_data,
  output logic              ram_wren,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready
);

  localparam int CNT_W = $clog2(LATENCY);
  // Loaded on the start edge; reaching zero marks the LATENCY-th edge.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  cap_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [AES_W-1:0]  cap_q;
  logic              match_q;
  logic              load_cnt;
  logic              sample;
  logic              last_xfer;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the strobes that steer the datapath registers.
  always_comb begin
    state_d  = state_q;
    load_cnt = 1'b0;
    sample   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_WAIT;
          load_cnt = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
          sample  = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (last_xfer) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latency down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_cnt) begin
      cnt_q <= CNT_LOAD;
    end else if (state_q == ST_WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Ciphertext capture and golden compare, both on the sample edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q   <= '0;
      match_q <= 1'b0;
    end else if (sample) begin
      cap_q   <= ct_in;
      match_q <= (ct_in == expected);
    end else if (load_cnt) begin
      match_q <= 1'b0;
    end
  end

  // RAM address pointer, wrapping naturally at 2^ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (last_xfer) begin
      ptr_q <= ptr_q + ADDR_W'(1);
    end
  end

  aes_byte_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .active     (state_q == ST_STREAM),
    .data       (cap_q),
    .byte_ready (byte_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .last_xfer  (last_xfer)
  );

  assign busy     = (state_q != ST_IDLE);
  assign ram_wren = (state_q == ST_CAPTURE);
  assign ram_data = ram_wren ? cap_q : '0;
  assign ram_addr = ptr_q;
  assign match    = match_q;
  assign done     = last_xfer;

endmodule
